mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single byte-addressed unified memory port between instruction fetch (IF) and
//  load/store (LS). It accepts req/gnt transactions, drives address/writeData/memRead/memWrite,
//  and registers read data. It performs byte and halfword stores as read-modify-write, because
//  the memory always writes 4 bytes. It also sign- or zero-extends sub-word loads.
//  Sits between the multicycle control/datapath and the memory block.
// PARAMETERS
//  MEM_BYTES  256  memory size in bytes; accesses with addr > MEM_BYTES-4 are out of range
// PORTS
//  clk           in   1   clock; all state changes on posedge
//  reset         in   1   synchronous, active-high
//  if_req        in   1   IF request; held with if_addr until if_gnt
//  if_addr       in   32  IF byte address (word fetch)
//  if_gnt        out  1   1-cycle pulse: IF request accepted
//  if_rvalid     out  1   1-cycle pulse: if_rdata valid
//  if_rdata      out  32  fetched word, registered
//  ls_req        in   1   LS request; held with the ls_* operands until ls_gnt
//  ls_we         in   1   1=store, 0=load
//  ls_size       in   2   0=byte, 1=half, 2=word (3 treated as word)
//  ls_unsigned   in   1   load zero-extend (1) / sign-extend (0)
//  ls_addr       in   32  LS byte address
//  ls_wdata      in   32  store data; low byte/half used for sub-word stores
//  ls_gnt        out  1   1-cycle pulse: LS request accepted
//  ls_rvalid     out  1   1-cycle pulse: load data valid, or store complete
//  ls_rdata      out  32  extended load data, registered; 0 for stores
//  ls_err        out  1   valid with ls_rvalid: access not performed
//  mem_address   out  32  to memory address
//  mem_writeData out  32  to memory writeData
//  mem_memRead   out  1   to memory memRead
//  mem_memWrite  out  1   to memory memWrite
//  mem_rdata     in   32  from memory memData (combinational, {b[a+3],b[a+2],b[a+1],b[a]})
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0, including *_gnt, *_rvalid, *_rdata, ls_err and mem_*.
//    last_gnt resets to IF. Reset during any state aborts the transaction; no mem_memWrite occurs
//    in the cycle reset is high or the cycle after it.
//  - States: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
//  - IDLE, arbitration:
//    - If exactly one req is high, grant it.
//    - If both are high, grant the requester not granted last (round-robin via last_gnt).
//    - The grant cycle T pulses gnt and latches addr, we, size, unsigned, wdata and the owner.
//    - Next state: ACCESS for loads, fetches and word stores; RMW_RD for byte/half stores.
//  - No new grant is issued until the FSM returns to IDLE: one outstanding transaction.
//  - ACCESS (T+1), memory driven from the latched address:
//    - Load/fetch: mem_memRead=1; the extended mem_rdata is captured into the owner's rdata
//      register.
//    - Word store: mem_memWrite=1, mem_writeData=wdata.
//  - RMW_RD (T+1): mem_memRead=1; capture mem_rdata into the merge register.
//  - RMW_WR (T+2): mem_memWrite=1; mem_writeData = merge with [7:0] (byte) or [15:0] (half)
//    replaced by wdata.
//  - RESP: owner rvalid=1 for exactly one cycle, then IDLE.
//    - Latency from grant: loads, fetches and word stores = 2 cycles (rvalid at T+2).
//    - Sub-word stores = 3 cycles (rvalid at T+3).
//  - Load extension: byte = mem_rdata[7:0]; half = mem_rdata[15:0]; extended per ls_unsigned.
//    Word loads are unmodified.
//  - mem_* outputs are 0 in IDLE and RESP. memRead and memWrite are never high together.
//  - Out of range (addr > MEM_BYTES-4): no memory strobe; go straight to RESP with ls_err=1 and
//    rdata=0. An IF out-of-range access returns if_rdata=0.
//  - rdata registers hold their value until the next response for the same requester.
//  - A req dropped before gnt is legal and is simply not granted.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    - An LS half with addr[0]=1, or an LS word with addr[1:0]!=0, is not performed.
//    - The access goes grant -> RESP, ls_rvalid at T+1 with ls_err=1 and ls_rdata=0, and no
//      memory strobes.
//    - IF with if_addr[1:0]!=0 is treated the same way, but no error output exists for IF:
//      if_rdata=0.
//  MISALIGN_TRAP_EN undefined: unaligned accesses proceed using the raw byte address;
//    ls_err is asserted only for out-of-range accesses.
// TESTING
//  1. if_req, if_addr=0x10, mem word 0xDEADBEEF -> if_gnt at T, memRead at T+1 with address
//     0x10, if_rvalid with if_rdata=0xDEADBEEF at T+2.
//  2. Both req high for 4 back-to-back rounds -> grants alternate; after reset, first grant goes
//     to LS (last_gnt=IF).
//  3. Word 0x11223344 at 0x80; sb ls_wdata=0xAA at 0x80 -> memRead at T+1, memWrite at T+2 with
//     0x112233AA, ls_rvalid at T+3.
//  4. Byte 0xF0 at 0x81: lb -> ls_rdata=0xFFFFFFF0; lbu -> ls_rdata=0x000000F0;
//     lh at 0x80 with bytes 0x34,0x82 -> 0xFFFF8234.
//  5. sh at addr 0xFD (out of range) -> no memWrite, ls_rvalid with ls_err=1 at T+1.
//     lw at 0x82 -> ls_err=1 with MISALIGN_TRAP_EN; normal load without it.
//  6. Reset asserted in RMW_RD -> next cycle IDLE, all outputs 0, no memWrite ever issued,
//     memory unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bundle of IF/LS request channels and memory port for mem_port_arbiter
// Purpose: groups the instruction-fetch and load/store req/gnt/rvalid channels together with
//          the unified memory port signals.
// Modports:
//   slave  - the arbiter: samples requests and mem_rdata, drives grants, responses, mem_* strobes
//   master - requesters and memory: drive requests and mem_rdata, observe everything else
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic        ls_unsigned;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_err;

  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memRead;
  logic        mem_memWrite;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output mem_address, mem_writeData, mem_memRead, mem_memWrite
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  mem_address, mem_writeData, mem_memRead, mem_memWrite
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin IF/LS arbiter for a single byte-addressed memory port
// Purpose: shares one memory port between instruction fetch and load/store. One transaction
//          is outstanding at a time. Byte/half stores are done as read-modify-write because the
//          memory always writes 4 bytes. Sub-word loads are sign/zero extended.
// Ports:
//   clk   - clock, all state changes on posedge
//   reset - synchronous, active-high
//   bus   - mem_port_arbiter_if.slave: IF and LS req/gnt/rvalid channels plus mem_* port
// Parameters:
//   MEM_BYTES - memory size in bytes; addresses above MEM_BYTES-4 are out of range
// Build option:
//   MISALIGN_TRAP_EN - when defined, misaligned LS half/word and IF accesses are rejected
//                      without touching memory
module mem_port_arbiter #(
  parameter int unsigned MEM_BYTES = 256
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, RESP} state_t;

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_t      state_q;
  logic        last_ls_q;
  logic        owner_ls_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic        if_rvalid_q;
  logic [31:0] if_rdata_q;
  logic        ls_rvalid_q;
  logic        ls_err_q;
  logic [31:0] ls_rdata_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_writeData_q;
  logic        mem_memRead_q;
  logic        mem_memWrite_q;

  logic        grant_if_d;
  logic        grant_ls_d;
  logic [31:0] sel_addr_d;
  logic        sel_we_d;
  logic [1:0]  sel_size_d;
  logic        sel_rmw_d;
  logic        sel_misalign_d;
  logic        sel_reject_d;

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'd0:    return {{24{~uns & d[7]}}, d[7:0]};
      2'd1:    return {{16{~uns & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic half);
    return half ? {old[31:16], wd[15:0]} : {old[31:8], wd[7:0]};
  endfunction

  // Grant is combinational in IDLE so a request withdrawn before this cycle is never granted;
  // on a tie the requester that did not win last time takes the port.
  assign grant_ls_d = (state_q == IDLE) && !reset && bus.ls_req && (!bus.if_req || !last_ls_q);
  assign grant_if_d = (state_q == IDLE) && !reset && bus.if_req && (!bus.ls_req || last_ls_q);

  assign sel_addr_d = grant_ls_d ? bus.ls_addr : bus.if_addr;
  assign sel_we_d   = grant_ls_d & bus.ls_we;
  assign sel_size_d = grant_ls_d ? bus.ls_size : 2'd2;
  assign sel_rmw_d  = sel_we_d & ~sel_size_d[1];

`ifdef MISALIGN_TRAP_EN
  assign sel_misalign_d = ((sel_size_d == 2'd1) && sel_addr_d[0]) ||
                          (sel_size_d[1] && (sel_addr_d[1:0] != 2'b00));
`else
  assign sel_misalign_d = 1'b0;
`endif

  assign sel_reject_d = (sel_addr_d > LAST_WORD) || sel_misalign_d;

  assign bus.if_gnt        = grant_if_d;
  assign bus.ls_gnt        = grant_ls_d;
  assign bus.if_rvalid     = if_rvalid_q;
  assign bus.if_rdata      = if_rdata_q;
  assign bus.ls_rvalid     = ls_rvalid_q;
  assign bus.ls_rdata      = ls_rdata_q;
  assign bus.ls_err        = ls_err_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writeData = mem_writeData_q;
  // Strobes are masked while reset is high so an aborted RMW can never write in that cycle.
  assign bus.mem_memRead   = mem_memRead_q & ~reset;
  assign bus.mem_memWrite  = mem_memWrite_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      last_ls_q       <= 1'b0;
      owner_ls_q      <= 1'b0;
      we_q            <= 1'b0;
      uns_q           <= 1'b0;
      size_q          <= 2'd0;
      wdata_q         <= 32'd0;
      if_rvalid_q     <= 1'b0;
      if_rdata_q      <= 32'd0;
      ls_rvalid_q     <= 1'b0;
      ls_err_q        <= 1'b0;
      ls_rdata_q      <= 32'd0;
      mem_address_q   <= 32'd0;
      mem_writeData_q <= 32'd0;
      mem_memRead_q   <= 1'b0;
      mem_memWrite_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_if_d || grant_ls_d) begin
            last_ls_q  <= grant_ls_d;
            owner_ls_q <= grant_ls_d;
            we_q       <= sel_we_d;
            size_q     <= sel_size_d;
            uns_q      <= bus.ls_unsigned;
            wdata_q    <= bus.ls_wdata;
            if (sel_reject_d) begin
              // Rejected access: answer next cycle with zero data, never strobe memory.
              state_q <= RESP;
              if (grant_ls_d) begin
                ls_rvalid_q <= 1'b1;
                ls_err_q    <= 1'b1;
                ls_rdata_q  <= 32'd0;
              end else begin
                if_rvalid_q <= 1'b1;
                if_rdata_q  <= 32'd0;
              end
            end else if (sel_rmw_d) begin
              state_q       <= RMW_RD;
              mem_address_q <= sel_addr_d;
              mem_memRead_q <= 1'b1;
            end else begin
              state_q       <= ACCESS;
              mem_address_q <= sel_addr_d;
              if (sel_we_d) begin
                mem_memWrite_q  <= 1'b1;
                mem_writeData_q <= bus.ls_wdata;
              end else begin
                mem_memRead_q <= 1'b1;
              end
            end
          end
        end

        ACCESS: begin
          state_q         <= RESP;
          mem_address_q   <= 32'd0;
          mem_writeData_q <= 32'd0;
          mem_memRead_q   <= 1'b0;
          mem_memWrite_q  <= 1'b0;
          if (owner_ls_q) begin
            ls_rvalid_q <= 1'b1;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= we_q ? 32'd0 : extend(bus.mem_rdata, size_q, uns_q);
          end else begin
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= bus.mem_rdata;
          end
        end

        RMW_RD: begin
          // mem_writeData_q doubles as the merge register: the old word with the new
          // byte/half spliced in is exactly what RMW_WR must drive.
          state_q         <= RMW_WR;
          mem_memRead_q   <= 1'b0;
          mem_memWrite_q  <= 1'b1;
          mem_writeData_q <= merge(bus.mem_rdata, wdata_q, size_q[0]);
        end

        RMW_WR: begin
          state_q         <= RESP;
          mem_address_q   <= 32'd0;
          mem_writeData_q <= 32'd0;
          mem_memWrite_q  <= 1'b0;
          ls_rvalid_q     <= 1'b1;
          ls_err_q        <= 1'b0;
          ls_rdata_q      <= 32'd0;
        end

        RESP: begin
          state_q     <= IDLE;
          if_rvalid_q <= 1'b0;
          ls_rvalid_q <= 1'b0;
          ls_err_q    <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_if;
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic preload_en = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   conflicts = 0;

  logic [7:0] mem [0:255];
  logic [7:0] ma;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MEM_BYTES(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign ma = bus.mem_address[7:0];
  assign bus.mem_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'hEF; mem[8'h11] <= 8'hBE; mem[8'h12] <= 8'hAD; mem[8'h13] <= 8'hDE;
      mem[8'h40] <= 8'h04; mem[8'h41] <= 8'h03; mem[8'h42] <= 8'h02; mem[8'h43] <= 8'h01;
      mem[8'h80] <= 8'h44; mem[8'h81] <= 8'h33; mem[8'h82] <= 8'h22; mem[8'h83] <= 8'h11;
      mem[8'hFC] <= 8'h0D; mem[8'hFD] <= 8'hF0; mem[8'hFE] <= 8'hFE; mem[8'hFF] <= 8'hCA;
    end else if (bus.mem_memWrite) begin
      mem[ma]         <= bus.mem_writeData[7:0];
      mem[ma + 8'd1]  <= bus.mem_writeData[15:8];
      mem[ma + 8'd2]  <= bus.mem_writeData[23:16];
      mem[ma + 8'd3]  <= bus.mem_writeData[31:24];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit is_if, bit we, logic [1:0] size, bit uns,
                              logic [31:0] addr, logic [31:0] wdata, logic [31:0] exp_rdata,
                              bit exp_err, int lat, int rd, int wr);
    vec_t v;
    v.is_if = is_if; v.we = we; v.size = size; v.uns = uns;
    v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr;
    return v;
  endfunction

  function automatic logic [31:0] out_flags();
    return {25'd0, bus.if_gnt, bus.if_rvalid, bus.ls_gnt, bus.ls_rvalid, bus.ls_err,
            bus.mem_memRead, bus.mem_memWrite};
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_flags"}, out_flags(), 32'd0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
    chk({tag, "_ls_rdata"}, bus.ls_rdata, 32'd0);
    chk({tag, "_mem_address"}, bus.mem_address, 32'd0);
    chk({tag, "_mem_writeData"}, bus.mem_writeData, 32'd0);
  endtask

  // Issue one request, follow it to its response and compare grant, latency, strobes and data.
  task automatic run_vec(input int idx, input vec_t v);
    bit          got;
    int          cyc;
    int          lat;
    int          nrd;
    int          nwr;
    bit          seen;
    logic [31:0] addr_seen;
    logic [31:0] rdata;
    logic        err;
    @(negedge clk);
    if (v.is_if) begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end else begin
      bus.ls_req = 1'b1; bus.ls_we = v.we; bus.ls_size = v.size;
      bus.ls_unsigned = v.uns; bus.ls_addr = v.addr; bus.ls_wdata = v.wdata;
    end
    got = 1'b0; cyc = 0;
    while (!got && cyc < 10) begin
      #1;
      if (v.is_if ? bus.if_gnt : bus.ls_gnt) got = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d_gnt", idx), {31'd0, got}, 32'd1);
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    got = 1'b0; lat = 1; nrd = 0; nwr = 0; seen = 1'b0; addr_seen = 32'd0;
    rdata = 32'hxxxxxxxx; err = 1'bx;
    while (!got && lat <= 6) begin
      #1;
      if (bus.mem_memRead) nrd++;
      if (bus.mem_memWrite) nwr++;
      if (bus.mem_memRead && bus.mem_memWrite) conflicts++;
      if ((bus.mem_memRead || bus.mem_memWrite) && !seen) begin
        seen = 1'b1; addr_seen = bus.mem_address;
      end
      if (v.is_if ? bus.if_rvalid : bus.ls_rvalid) begin
        got = 1'b1;
        rdata = v.is_if ? bus.if_rdata : bus.ls_rdata;
        err = bus.ls_err;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    chk($sformatf("v%0d_rvalid", idx), {31'd0, got}, 32'd1);
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
    if (!v.is_if) chk($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_reads", idx), nrd, v.exp_rd);
    chk($sformatf("v%0d_writes", idx), nwr, v.exp_wr);
    chk($sformatf("v%0d_mem_address", idx), addr_seen,
        (v.exp_rd + v.exp_wr != 0) ? v.addr : 32'd0);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_rvalid_drop", idx),
        {31'd0, (v.is_if ? bus.if_rvalid : bus.ls_rvalid)}, 32'd0);
  endtask

  vec_t vecs [19];

  initial begin
    int          n;
    int          dual;
    int          wr;
    bit          who [4];
    logic [31:0] word;

    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = 2'd0; bus.ls_unsigned = 1'b0;
    bus.ls_addr = 32'd0; bus.ls_wdata = 32'd0;

    //            is_if we size uns addr          wdata          exp_rdata     err lat rd wr
    vecs[0]  = mk(1, 0, 2'd2, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 2, 1, 0);
    vecs[1]  = mk(1, 0, 2'd2, 0, 32'h0000_0104, 32'h0,         32'h0000_0000, 0, 1, 0, 0);
    vecs[2]  = mk(0, 1, 2'd0, 0, 32'h0000_0080, 32'h1234_56AA, 32'h0000_0000, 0, 3, 1, 1);
    vecs[3]  = mk(0, 0, 2'd2, 0, 32'h0000_0080, 32'h0,         32'h1122_33AA, 0, 2, 1, 0);
    vecs[4]  = mk(0, 1, 2'd0, 0, 32'h0000_0081, 32'h0000_00F0, 32'h0000_0000, 0, 3, 1, 1);
    vecs[5]  = mk(0, 0, 2'd0, 0, 32'h0000_0081, 32'h0,         32'hFFFF_FFF0, 0, 2, 1, 0);
    vecs[6]  = mk(0, 0, 2'd0, 1, 32'h0000_0081, 32'h0,         32'h0000_00F0, 0, 2, 1, 0);
    vecs[7]  = mk(0, 1, 2'd1, 0, 32'h0000_0080, 32'hFFFF_8234, 32'h0000_0000, 0, 3, 1, 1);
    vecs[8]  = mk(0, 0, 2'd1, 0, 32'h0000_0080, 32'h0,         32'hFFFF_8234, 0, 2, 1, 0);
    vecs[9]  = mk(0, 0, 2'd1, 1, 32'h0000_0080, 32'h0,         32'h0000_8234, 0, 2, 1, 0);
    vecs[10] = mk(0, 0, 2'd2, 0, 32'h0000_0080, 32'h0,         32'h1122_8234, 0, 2, 1, 0);
    vecs[11] = mk(0, 1, 2'd1, 0, 32'h0000_00FD, 32'h0000_BEEF, 32'h0000_0000, 1, 1, 0, 0);
    vecs[12] = mk(0, 0, 2'd2, 0, 32'h0000_00FC, 32'h0,         32'hCAFE_F00D, 0, 2, 1, 0);
    vecs[13] = mk(0, 0, 2'd2, 0, 32'h0000_00FD, 32'h0,         32'h0000_0000, 1, 1, 0, 0);
    vecs[14] = mk(0, 1, 2'd2, 0, 32'h0000_0020, 32'h5A5A_1234, 32'h0000_0000, 0, 2, 0, 1);
    vecs[15] = mk(0, 0, 2'd3, 0, 32'h0000_0020, 32'h0,         32'h5A5A_1234, 0, 2, 1, 0);
    vecs[16] = mk(0, 0, 2'd0, 0, 32'h0000_0021, 32'h0,         32'h0000_0012, 0, 2, 1, 0);
`ifdef MISALIGN_TRAP_EN
    vecs[17] = mk(0, 0, 2'd2, 0, 32'h0000_0082, 32'h0,         32'h0000_0000, 1, 1, 0, 0);
    vecs[18] = mk(1, 0, 2'd2, 0, 32'h0000_0012, 32'h0,         32'h0000_0000, 0, 1, 0, 0);
`else
    vecs[17] = mk(0, 0, 2'd2, 0, 32'h0000_0082, 32'h0,         32'h0000_1122, 0, 2, 1, 0);
    vecs[18] = mk(1, 0, 2'd2, 0, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 0, 2, 1, 0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    preload_en = 1'b0;
    reset = 1'b0;

    // Round robin: both requesters held high, LS wins first since last_gnt resets to IF.
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd2; bus.ls_addr = 32'h20;
    n = 0; dual = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      #1;
      if (bus.if_gnt && bus.ls_gnt) dual++;
      if (bus.if_gnt || bus.ls_gnt) begin
        who[n] = bus.ls_gnt;
        n++;
      end
      @(negedge clk);
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    chk("rr_grant_count", n, 4);
    chk("rr_dual_grant", dual, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_round%0d_is_ls", i), {31'd0, who[i]},
                                    {31'd0, (i % 2 == 0)});
    repeat (4) @(negedge clk);

    for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);
    chk("rd_wr_overlap", conflicts, 0);

    // Reset while the sub-word store sits in RMW_RD: nothing may be written.
    @(negedge clk);
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'd0; bus.ls_unsigned = 1'b0;
    bus.ls_addr = 32'h40; bus.ls_wdata = 32'h0000_00EE;
    #1;
    chk("rst_rmw_gnt", {31'd0, bus.ls_gnt}, 32'd1);
    @(negedge clk);
    bus.ls_req = 1'b0;
    #1;
    chk("rst_rmw_read", {31'd0, bus.mem_memRead}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_rmw_no_write_in_reset", {31'd0, bus.mem_memWrite}, 32'd0);
    @(negedge clk);
    #1;
    check_all_zero("rst_rmw_after");
    reset = 1'b0;
    wr = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (bus.mem_memWrite) wr++;
    end
    chk("rst_rmw_writes", wr, 0);
    word = {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]};
    chk("rst_rmw_mem_unchanged", word, 32'h0102_0304);
    run_vec(99, mk(0, 0, 2'd2, 0, 32'h0000_0040, 32'h0, 32'h0102_0304, 0, 2, 1, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
